// File: rtl/data_mem_ctrl.sv
// Load/store sequencer for a single-port word memory with one-cycle read latency.
// Does lane extraction and sign/zero extension for loads, and read-modify-write for sub-word stores.
module data_mem_ctrl #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_func3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [31:0]       resp_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_MERGE,
    S_WRITE,
    S_ERR
  } state_t;

  state_t            state_q, state_d;
  logic              we_q, we_d;
  logic [2:0]        size_q, size_d;
  logic              sign_q, sign_d;
  logic [1:0]        lane_q, lane_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       wword_q, wword_d;

  logic [2:0]  req_size;
  logic        req_bad;
  logic [31:0] ld_shift;
  logic [31:0] ld_data;
  logic [3:0]  byte_en;
  logic [31:0] wd_shift;
  logic [31:0] st_merged;
  logic        unused_addr_hi;

  assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

  always_comb begin
    req_size = 3'b000;
    case (req_func3[1:0])
      2'b00:   req_size = 3'b001;
      2'b01:   req_size = 3'b011;
      2'b10:   req_size = 3'b111;
      default: req_size = 3'b000;
    endcase
    req_bad = (req_func3[1:0] == 2'b11) || (req_func3 == 3'b110) ||
              (req_we && req_func3[2]) ||
              ((req_func3[1:0] == 2'b01) && req_addr[0]) ||
              ((req_func3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
  end

  // Load path: mem_rdata is valid in MERGE, one cycle after the READ strobe.
  always_comb begin
    ld_shift = mem_rdata >> {lane_q, 3'b000};
    case (size_q)
      3'b001:  ld_data = {{24{sign_q & ld_shift[7]}}, ld_shift[7:0]};
      3'b011:  ld_data = {{16{sign_q & ld_shift[15]}}, ld_shift[15:0]};
      default: ld_data = mem_rdata;
    endcase
  end

  always_comb begin
    byte_en  = {1'b0, size_q} << lane_q;
    wd_shift = wdata_q << {lane_q, 3'b000};
    st_merged = mem_rdata;
    for (int unsigned i = 0; i < 4; i++) begin
      if (byte_en[i]) st_merged[8*i +: 8] = wd_shift[8*i +: 8];
    end
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    sign_d  = sign_q;
    lane_d  = lane_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wword_d = wword_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          size_d  = req_size;
          sign_d  = ~req_func3[2];
          lane_d  = req_addr[1:0];
          addr_d  = req_addr[ADDR_W+1:2];
          wdata_d = req_wdata;
          if (req_bad) begin
            state_d = S_ERR;
          end else if (req_we && (req_size == 3'b111)) begin
            wword_d = req_wdata;
            state_d = S_WRITE;
          end else begin
            state_d = S_READ;
          end
        end
      end
      S_READ:  state_d = S_MERGE;
      S_MERGE: begin
        if (we_q) begin
          wword_d = st_merged;
          state_d = S_WRITE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WRITE: state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      size_q  <= '0;
      sign_q  <= 1'b0;
      lane_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wword_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      sign_q  <= sign_d;
      lane_q  <= lane_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wword_q <= wword_d;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign mem_re     = (state_q == S_READ);
  assign mem_we     = (state_q == S_WRITE);
  assign mem_addr   = addr_q;
  assign mem_wdata  = (state_q == S_WRITE) ? wword_q : '0;
  assign resp_valid = (state_q == S_WRITE) || (state_q == S_ERR) ||
                      ((state_q == S_MERGE) && !we_q);
  assign resp_err   = (state_q == S_ERR);
  assign resp_rdata = ((state_q == S_MERGE) && !we_q) ? ld_data : '0;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: directed vector table, reset-abort sequence and
// random traffic checked against a byte-level memory model.
module tb_data_mem_ctrl;
  localparam int AW = 10;

  logic          clk;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [2:0]    req_func3;
  logic [31:0]   req_addr;
  logic [31:0]   req_wdata;
  logic          resp_valid;
  logic          resp_err;
  logic [31:0]   resp_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_re;
  logic          mem_we;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  logic [31:0] mem [0:(1<<AW)-1];
  logic [31:0] ref_mem [0:(1<<AW)-1];
  logic          pre_we;
  logic [AW-1:0] pre_a;
  logic [31:0]   pre_d;

  int total = 0;
  int bad = 0;

  data_mem_ctrl #(.ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_func3(req_func3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory with one-cycle read latency; pre_we is a bench-only preload port.
  always @(posedge clk) begin
    if (pre_we) mem[pre_a] <= pre_d;
    else if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        err;
    logic [31:0] rd;
    int          lat;
    logic [31:0] ww;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wd, input logic err, input logic [31:0] rd,
                              input int lat, input logic [31:0] ww);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wd = wd;
    v.err = err; v.rd = rd; v.lat = lat; v.ww = ww;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic poke(input int idx, input logic [31:0] d);
    pre_we = 1'b1;
    pre_a  = idx[AW-1:0];
    pre_d  = d;
    ref_mem[idx] = d;
    @(posedge clk);
    #1 pre_we = 1'b0;
  endtask

  // Reference semantics: byte-addressed view of the word array.
  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, output logic err, output logic [31:0] rd,
                       output int lat, output logic [31:0] ww);
    int sz, nb, lane, idx;
    longint unsigned v, msk;
    logic [31:0] w;
    sz   = int'(f3[1:0]);
    nb   = 1 << sz;
    lane = int'(addr[1:0]);
    idx  = int'(addr[AW+1:2]);
    err  = (sz == 3) || (f3 == 3'b110) || (we && f3[2]) ||
           (sz == 1 && addr[0]) || (sz == 2 && addr[1:0] != 2'b00);
    rd = '0;
    ww = '0;
    if (err) begin
      lat = 1;
    end else if (!we) begin
      lat = 2;
      msk = (64'd1 << (8*nb)) - 1;
      v = (longint'(ref_mem[idx]) >> (8*lane)) & msk;
      if (!f3[2] && ((v >> (8*nb-1)) & 1) == 1) v = v | ~msk;
      rd = v[31:0];
    end else begin
      lat = (nb == 4) ? 1 : 3;
      w = ref_mem[idx];
      for (int i = 0; i < nb; i++) w[8*(lane+i) +: 8] = wd[8*i +: 8];
      ref_mem[idx] = w;
      ww = w;
    end
  endtask

  task automatic run_txn(input string nm, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd, input logic err,
                         input logic [31:0] rd, input int lat, input logic [31:0] ww);
    int got_lat, re_n, we_n, both, we_k;
    logic got_err, addr_ok;
    logic [31:0] got_rd, got_ww;
    got_lat = 0; re_n = 0; we_n = 0; both = 0; we_k = 0;
    got_err = 1'bx; got_rd = 'x; got_ww = 'x; addr_ok = 1'b1;
    @(negedge clk);
    chk({nm, " ready"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_func3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge clk);
    #1;
    // Junk on the request bus while busy must be ignored.
    req_valid = 1'($urandom_range(0, 1));
    req_we = 1'($urandom_range(0, 1));
    req_func3 = 3'($urandom_range(0, 7));
    req_addr = $urandom;
    req_wdata = $urandom;
    for (int k = 1; k <= 6 && got_lat == 0; k++) begin
      @(negedge clk);
      if (mem_re) re_n++;
      if (mem_we) begin
        we_n++;
        we_k = k;
        got_ww = mem_wdata;
      end
      if (mem_re && mem_we) both++;
      if ((mem_re || mem_we) && mem_addr !== addr[AW+1:2]) addr_ok = 1'b0;
      if (resp_valid) begin
        got_lat = k;
        got_err = resp_err;
        got_rd  = resp_rdata;
        req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    chk({nm, " latency"}, got_lat, lat);
    chk({nm, " err"}, {31'd0, got_err}, {31'd0, err});
    chk({nm, " rdata"}, got_rd, rd);
    chk({nm, " re_count"}, re_n, (lat >= 2) ? 1 : 0);
    chk({nm, " we_count"}, we_n, (we && !err) ? 1 : 0);
    chk({nm, " mem_addr"}, {31'd0, addr_ok}, 32'd1);
    chk({nm, " re_we_overlap"}, both, 0);
    if (we && !err) begin
      chk({nm, " wdata"}, got_ww, ww);
      chk({nm, " we_cycle"}, we_k, lat);
    end
  endtask

  initial begin
    logic        e;
    logic [31:0] r, w, a, wd;
    logic [2:0]  f3;
    logic        we, we_seen;
    int          l, diff;

    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_func3 = '0;
    req_addr = '0; req_wdata = '0; pre_we = 1'b0; pre_a = '0; pre_d = '0;

    for (int i = 'h10; i < 'h18; i++) poke(i, $urandom);
    poke('h10, 32'h8899AABB);
    poke('h12, 32'h0BADF00D);

    @(negedge clk);
    chk("reset ready", {31'd0, req_ready}, 32'd1);
    chk("reset resp", {29'd0, resp_valid, resp_err, mem_re}, 32'd0);
    chk("reset rdata", resp_rdata, 32'd0);
    chk("reset mem_we", {31'd0, mem_we}, 32'd0);
    chk("reset mem_addr", {22'd0, mem_addr}, 32'd0);
    chk("reset mem_wdata", mem_wdata, 32'd0);
    rst_n = 1'b1;

    tbl.push_back(mk(0, 3'b000, 32'h41, 0, 0, 32'hFFFFFFAA, 2, 0));
    tbl.push_back(mk(0, 3'b100, 32'h41, 0, 0, 32'h000000AA, 2, 0));
    tbl.push_back(mk(0, 3'b001, 32'h42, 0, 0, 32'hFFFF8899, 2, 0));
    tbl.push_back(mk(0, 3'b101, 32'h42, 0, 0, 32'h00008899, 2, 0));
    tbl.push_back(mk(0, 3'b010, 32'h40, 0, 0, 32'h8899AABB, 2, 0));
    tbl.push_back(mk(1, 3'b000, 32'h43, 32'h12345677, 0, 0, 3, 32'h7799AABB));
    tbl.push_back(mk(0, 3'b010, 32'h40, 0, 0, 32'h7799AABB, 2, 0));
    tbl.push_back(mk(0, 3'b000, 32'h40, 0, 0, 32'hFFFFFFBB, 2, 0));
    tbl.push_back(mk(0, 3'b101, 32'h40, 0, 0, 32'h0000AABB, 2, 0));
    tbl.push_back(mk(1, 3'b010, 32'h44, 32'hDEADBEEF, 0, 0, 1, 32'hDEADBEEF));
    tbl.push_back(mk(0, 3'b010, 32'h44, 0, 0, 32'hDEADBEEF, 2, 0));
    tbl.push_back(mk(1, 3'b000, 32'h45, 32'h00000055, 0, 0, 3, 32'hDEAD55EF));
    tbl.push_back(mk(1, 3'b001, 32'h46, 32'h0000CAFE, 0, 0, 3, 32'hCAFE55EF));
    tbl.push_back(mk(0, 3'b010, 32'h44, 0, 0, 32'hCAFE55EF, 2, 0));
    tbl.push_back(mk(0, 3'b010, 32'h42, 0, 1, 0, 1, 0));
    tbl.push_back(mk(1, 3'b001, 32'h41, 32'h1111, 1, 0, 1, 0));
    tbl.push_back(mk(1, 3'b100, 32'h40, 32'h2222, 1, 0, 1, 0));
    tbl.push_back(mk(0, 3'b001, 32'h43, 0, 1, 0, 1, 0));
    tbl.push_back(mk(0, 3'b011, 32'h40, 0, 1, 0, 1, 0));
    tbl.push_back(mk(0, 3'b110, 32'h40, 0, 1, 0, 1, 0));
    tbl.push_back(mk(0, 3'b000, 32'h47, 0, 0, 32'hFFFFFFCA, 2, 0));

    foreach (tbl[i]) begin
      model(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wd, e, r, l, w);
      run_txn($sformatf("vec%0d", i), tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wd,
              tbl[i].err, tbl[i].rd, tbl[i].lat, tbl[i].ww);
    end

    // Reset during the READ of a sub-word store: the write must never happen.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_func3 = 3'b000;
    req_addr = 32'h48; req_wdata = 32'h000000EE;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("rst_mid read", {31'd0, mem_re}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid strobes", {30'd0, mem_re, mem_we}, 32'd0);
    chk("rst_mid ready", {31'd0, req_ready}, 32'd1);
    we_seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (mem_we) we_seen = 1'b1;
    end
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (mem_we) we_seen = 1'b1;
    end
    chk("rst_mid no_write", {31'd0, we_seen}, 32'd0);
    chk("rst_mid ready_after", {31'd0, req_ready}, 32'd1);
    run_txn("rst_mid reload", 1'b0, 3'b010, 32'h48, 32'd0, 1'b0, 32'h0BADF00D, 2, 32'd0);

    for (int n = 0; n < 200; n++) begin
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a  = ($urandom & 32'hFFFF_F000) | (32'h40 + 32'($urandom_range(0, 31)));
      wd = $urandom;
      model(we, f3, a, wd, e, r, l, w);
      run_txn($sformatf("rnd%0d", n), we, f3, a, wd, e, r, l, w);
    end

    @(negedge clk);
    diff = 0;
    for (int i = 'h10; i < 'h18; i++) if (mem[i] !== ref_mem[i]) diff++;
    chk("mem_image", diff, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
